// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver running on the system clock.
// Bit timing comes from the start-bit falling edge. Each bit is sampled at mid-period.
// A received byte is presented with a one-cycle strobe.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_rx         serial input, asynchronous to i_clk, idles high
//   o_data       last correctly received byte, held until the next good frame
//   o_valid      one-cycle pulse, o_data is new in that cycle
//   o_frame_err  one-cycle pulse, stop bit was sampled low
//   o_busy       high whenever a frame is being received or awaited to clear
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 1250
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } state_e;

  state_e          state_q, state_d;
  logic            rx_meta_q, rx_s_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            frame_err_q, frame_err_d;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d = StStart;
        end
      end

      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d   = StData;
            bit_idx_d = '0;
          end else begin
            // Line went back high before mid-start: treat as a glitch.
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            // Leaving at mid-stop lets a back-to-back start edge be caught.
            state_d = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StWaitIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StWaitIdle: begin
        cnt_d = '0;
        // A held-low line (break) must not be mistaken for a new start bit.
        if (rx_s_q) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = frame_err_q;
  assign o_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx. Instance a uses 16 clocks per bit.
// Instance b uses the default bit period. Frames are pushed as expected events
// when their stop bit starts. A monitor pops and compares on every output pulse.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b, err_a, err_b, busy_a, busy_b;

  uart_rx #(.CLKS_PER_BIT(16)) u_a (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx       (rx_a),
    .o_data     (data_a),
    .o_valid    (valid_a),
    .o_frame_err(err_a),
    .o_busy     (busy_a)
  );

  uart_rx u_b (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx       (rx_b),
    .o_data     (data_b),
    .o_valid    (valid_b),
    .o_frame_err(err_b),
    .o_busy     (busy_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    bit         err;
    logic [7:0] data;
  } ev_t;

  ev_t        q_a[$];
  ev_t        q_b[$];
  logic [7:0] good_a = 8'h00;
  logic [7:0] good_b = 8'h00;
  int         vt_prev = 0;
  int         vt_last = 0;
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q_a.size() : q_b.size();
  endfunction

  task automatic set_rx(input int d, input logic v);
    if (d == 0) rx_a = v;
    else        rx_b = v;
  endtask

  // Reference model of one frame: start bit, 8 data bits LSB first, then the stop bit.
  // A high stop bit yields the byte. A low stop bit yields a framing error.
  // Bit k ends num*(k+1)/den clocks after the start edge.
  // ndata < 8 aborts after that many data bits, and no event is expected.
  task automatic send(input int d, input logic [7:0] b, input bit stop_hi,
                      input int num, input int den, input int ndata);
    int   t0;
    int   last;
    logic v;
    ev_t  ev;
    t0   = cyc;
    last = (ndata < 8) ? ndata : 9;
    for (int k = 0; k <= last; k++) begin
      if (k == 0)      v = 1'b0;
      else if (k == 9) v = stop_hi;
      else             v = b[k-1];
      if (k == 9) begin
        ev.err  = !stop_hi;
        ev.data = b;
        if (d == 0) q_a.push_back(ev);
        else        q_b.push_back(ev);
      end
      set_rx(d, v);
      while (cyc < t0 + ((k + 1) * num) / den) @(negedge clk);
    end
  endtask

  task automatic drain(input int d, input int limit);
    int n = 0;
    while (qsize(d) != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("drain_%0d", d), qsize(d), 0);
  endtask

  task automatic check_pulse(input int d, input logic v, input logic e, input logic [7:0] dat);
    ev_t        ev;
    logic [7:0] good;
    chk($sformatf("pulse_exclusive_%0d", d), int'(v && e), 0);
    if (qsize(d) == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_pulse_%0d: valid=%0b err=%0b data=0x%0h expected no pulse",
               d, v, e, dat);
      return;
    end
    if (d == 0) ev = q_a.pop_front();
    else        ev = q_b.pop_front();
    good = (d == 0) ? good_a : good_b;
    if (ev.err) begin
      chk($sformatf("frame_err_flag_%0d", d), int'(e), 1);
      chk($sformatf("data_held_on_err_%0d", d), int'(dat), int'(good));
    end else begin
      chk($sformatf("valid_flag_%0d", d), int'(v), 1);
      chk($sformatf("data_%0d", d), int'(dat), int'(ev.data));
      if (d == 0) begin
        good_a  = ev.data;
        vt_prev = vt_last;
        vt_last = cyc;
      end else begin
        good_b = ev.data;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (valid_a || err_a) check_pulse(0, valid_a, err_a, data_a);
      if (valid_b || err_b) check_pulse(1, valid_b, err_b, data_b);
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data_a"},  int'(data_a), 0);
    chk({tag, "_valid_a"}, int'(valid_a), 0);
    chk({tag, "_err_a"},   int'(err_a), 0);
    chk({tag, "_busy_a"},  int'(busy_a), 0);
    chk({tag, "_data_b"},  int'(data_b), 0);
    chk({tag, "_busy_b"},  int'(busy_b), 0);
  endtask

  initial begin
    bit saw_busy;
    int gap;
    bit st;

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 1: single frame 0x55
    send(0, 8'h55, 1'b1, 16, 1, 8);
    rx_a = 1'b1;
    repeat (10) @(negedge clk);
    drain(0, 100);
    chk("idle_busy_after_55", int'(busy_a), 0);

    // 2: back-to-back frames, no idle gap
    send(0, 8'hA5, 1'b1, 16, 1, 8);
    send(0, 8'h3C, 1'b1, 16, 1, 8);
    rx_a = 1'b1;
    repeat (20) @(negedge clk);
    drain(0, 100);
    total++;
    if ((vt_last - vt_prev) < 159 || (vt_last - vt_prev) > 161) begin
      bad++;
      $display("FAIL b2b_gap: got %0d cycles expected 160+-1", vt_last - vt_prev);
    end

    // 3: short glitch shorter than half a bit
    saw_busy = 1'b0;
    rx_a = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (busy_a) saw_busy = 1'b1;
    end
    rx_a = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (busy_a) saw_busy = 1'b1;
    end
    chk("glitch_saw_busy", int'(saw_busy), 1);
    chk("glitch_busy_low", int'(busy_a), 0);
    chk("glitch_data_kept", int'(data_a), int'(good_a));

    // 4: framing error with line held low, then a good frame
    send(0, 8'h81, 1'b0, 16, 1, 8);
    repeat (40) @(negedge clk);
    chk("break_busy_held", int'(busy_a), 1);
    rx_a = 1'b1;
    repeat (20) @(negedge clk);
    drain(0, 100);
    chk("after_break_data", int'(data_a), 8'h3C);
    send(0, 8'h42, 1'b1, 16, 1, 8);
    rx_a = 1'b1;
    repeat (20) @(negedge clk);
    drain(0, 100);

    // Randomized frames: random bytes, occasional bad stop bits, random gaps
    for (int i = 0; i < 24; i++) begin
      st = ($urandom_range(0, 4) != 0);
      send(0, 8'($urandom), st, 16, 1, 8);
      rx_a = 1'b1;
      gap = st ? $urandom_range(0, 12) : $urandom_range(4, 16);
      repeat (gap) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    drain(0, 100);

    // 5: reset during data bit 4 of 0xFF, then 0x12
    send(0, 8'hFF, 1'b1, 16, 1, 4);
    rx_a = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("midframe_reset");
    good_a = 8'h00;
    good_b = 8'h00;
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("after_reset_idle", int'(busy_a), 0);
    send(0, 8'h12, 1'b1, 16, 1, 8);
    rx_a = 1'b1;
    repeat (20) @(negedge clk);
    drain(0, 100);

    // 6: default bit period, nominal and 3% fast baud
    send(1, 8'h0F, 1'b1, 1250, 1, 8);
    rx_b = 1'b1;
    repeat (2000) @(negedge clk);
    drain(1, 3000);
    send(1, 8'h0F, 1'b1, 125000, 103, 8);
    rx_b = 1'b1;
    repeat (2000) @(negedge clk);
    drain(1, 3000);
    chk("fast_baud_data", int'(data_b), 8'h0F);
    chk("final_busy_b", int'(busy_b), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
